// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared defaults and header-field constants for the router output FIFO.
//   ROUTER_WIDTH / ROUTER_DEPTH / ROUTER_TIMEOUT : parameter defaults
//   LEN_MSB / LEN_LSB                            : payload-length slice of a header byte
//   PKT_CNT_W                                    : width of the packet byte counter
// -----------------------------------------------------------------------------
package router_pkg;

    localparam int ROUTER_WIDTH   = 8;
    localparam int ROUTER_DEPTH   = 16;
    localparam int ROUTER_TIMEOUT = 30;

    // Header byte layout: [7:2] payload length, [1:0] destination address.
    localparam int LEN_MSB   = 7;
    localparam int LEN_LSB   = 2;
    localparam int PKT_CNT_W = LEN_MSB - LEN_LSB + 1;

    // Bytes still to leave after a header: the payload plus the parity byte.
    function automatic logic [PKT_CNT_W-1:0] header_count(input logic [PKT_CNT_W-1:0] len);
        return len + PKT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/router_timeout.sv
// -----------------------------------------------------------------------------
// router_timeout
// Idle-cycle counter that raises a one-cycle terminal pulse after TIMEOUT
// counted cycles. Used by router_out_fifo only when ROUTER_FIFO_TIMEOUT_EN
// is defined.
//   clk      : clock, all logic on posedge
//   resetn   : synchronous active-low reset
//   inc      : count this cycle
//   clr      : restart the count (wins over inc)
//   terminal : count has reached TIMEOUT-1; counter restarts on the next edge
// -----------------------------------------------------------------------------
module router_timeout
    import router_pkg::*;
#(
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic clk,
    input  logic resetn,
    input  logic inc,
    input  logic clr,
    output logic terminal
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    assign terminal = (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!resetn || clr || terminal) begin
            count <= '0;
        end else if (inc) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // register samples pre-edge values, independent of block order.
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/router_out_fifo.sv
// -----------------------------------------------------------------------------
// router_out_fifo
// Per-destination output FIFO of the router. Each entry is a byte plus a
// header flag. Reading a header loads a packet byte counter; once the packet
// has drained and no read is pending, dout returns to zero.
// Optional feature (macro ROUTER_FIFO_TIMEOUT_EN): if the destination leaves
// data unread for TIMEOUT cycles, soft_rst pulses and the FIFO flushes itself.
//   clk       : clock, all logic on posedge
//   resetn    : synchronous active-low reset
//   we        : write enable (ignored while full)
//   lfd_state : current write is a header byte
//   data_in   : byte to store
//   reen      : read enable (ignored while empty)
//   dout      : registered read data
//   vld_out   : FIFO holds at least one entry
//   full      : no free entry
//   empty     : no stored entry
//   soft_rst  : one-cycle timeout flush pulse (0 when the feature is off)
// -----------------------------------------------------------------------------
module router_out_fifo
    import router_pkg::*;
#(
    parameter int WIDTH   = ROUTER_WIDTH,
    parameter int DEPTH   = ROUTER_DEPTH,
    parameter int TIMEOUT = ROUTER_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             we,
    input  logic             lfd_state,
    input  logic [WIDTH-1:0] data_in,
    input  logic             reen,
    output logic [WIDTH-1:0] dout,
    output logic             vld_out,
    output logic             full,
    output logic             empty,
    output logic             soft_rst
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;

    if (WIDTH < 8 || DEPTH < 2 || DEPTH != (1 << ADDR_W) || TIMEOUT < 2) begin : g_param_check
        $error("router_out_fifo: WIDTH>=8, power-of-two DEPTH>=2 and TIMEOUT>=2 required");
    end

    logic [WIDTH:0]         mem [DEPTH];
    logic [PTR_W-1:0]       wptr;
    logic [PTR_W-1:0]       rptr;
    logic [PKT_CNT_W-1:0]   pkt_cnt;
    logic [WIDTH:0]         rd_entry;
    logic                   do_wr;
    logic                   do_rd;
    logic                   flush;

    // Extra pointer MSB distinguishes a full ring from an empty one.
    assign empty   = (wptr == rptr);
    assign full    = (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr[ADDR_W] != rptr[ADDR_W]);
    assign vld_out = !empty;

    // A flush cycle drops any write so nothing survives into the cleared FIFO.
    assign do_wr    = we && !full && !flush;
    assign do_rd    = reen && !empty;
    assign rd_entry = mem[rptr[ADDR_W-1:0]];

`ifdef ROUTER_FIFO_TIMEOUT_EN
    router_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .resetn   (resetn),
        .inc      (vld_out && !reen),
        .clr      (reen || empty),
        .terminal (soft_rst)
    );
`else
    assign soft_rst = 1'b0;
`endif

    assign flush = soft_rst;

    // NOTE: the storage array has no reset; clearing the pointers already
    // makes every entry unreachable, and a reset here would block RAM mapping.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wptr    <= '0;
            rptr    <= '0;
            pkt_cnt <= '0;
            dout    <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (do_rd) begin
                rptr <= rptr + PTR_W'(1);
                dout <= rd_entry[WIDTH-1:0];
                if (rd_entry[WIDTH]) begin
                    pkt_cnt <= header_count(rd_entry[LEN_MSB:LEN_LSB]);
                end else if (pkt_cnt != '0) begin
                    pkt_cnt <= pkt_cnt - PKT_CNT_W'(1);
                end
            end else if (pkt_cnt == '0) begin
                // Packet fully delivered: stop presenting stale data.
                dout <= '0;
            end
        end
    end

endmodule
